control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 216 +++++++++++++++++++++
 tb/tb_control_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multicycle RISC-V style control FSM driving datapath strobes from the current state
// Ports:
//   clk, reset (async, active-high)         clock and reset; reset forces FETCH and all outputs low
//   instruction[31:0]                       current IR contents (opcode, funct3, funct7[5] used)
//   alu_equal/less/greater/zero             ALU compare flags, used only for the BRANCH decision
//   PCWriteState, PCSource[1:0]             PC load enable and PC source select
//   DataMemSrc, IntCause, EPCWrite, CauseWrite  exception path controls
//   ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[3:0]  ALU operand and operation selects
//   LoadAOut, LoadRegA, LoadRegB, RegWrite, LoadMDR, IRWrite, DMemOp  register/memory strobes
//   MemToReg[1:0], LoadSplice[1:0], StoreSplice[1:0]  writeback source and access width
//   state[4:0]                              current FSM state, for debug
// Build option: define CTRL_EXC_EN to enable the EXC -> EXC_LD exception sequence.
module control_unit #(
    parameter logic [4:0] RESET_STATE = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        alu_equal,
    input  logic        alu_less,
    input  logic        alu_greater,
    input  logic        alu_zero,
    output logic        PCWriteState,
    output logic [1:0]  PCSource,
    output logic        DataMemSrc,
    output logic        IntCause,
    output logic        EPCWrite,
    output logic        CauseWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic        LoadAOut,
    output logic        LoadRegA,
    output logic        LoadRegB,
    output logic        RegWrite,
    output logic        LoadMDR,
    output logic        IRWrite,
    output logic        DMemOp,
    output logic [1:0]  MemToReg,
    output logic [1:0]  LoadSplice,
    output logic [1:0]  StoreSplice,
    output logic [4:0]  state
);
    typedef enum logic [4:0] {
        FETCH  = 5'd0,
        FETCH2 = 5'd1,
        DECODE = 5'd2,
        EXEC_R = 5'd3,
        EXEC_I = 5'd4,
        LUI    = 5'd5,
        WB_ALU = 5'd6,
        ADDR   = 5'd7,
        MEM_RD = 5'd8,
        MEM_LD = 5'd9,
        WB_LD  = 5'd10,
        MEM_WR = 5'd11,
        BRANCH = 5'd12,
        BR_FIX = 5'd13,
        JAL    = 5'd14,
        JALR   = 5'd15
`ifdef CTRL_EXC_EN
        ,
        EXC    = 5'd16,
        EXC_LD = 5'd17
`endif
    } state_t;

    typedef struct packed {
        logic       pcw;
        logic [1:0] pcsrc;
        logic       dms;
        logic       cause;
        logic       epcw;
        logic       causew;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic       ldaout;
        logic       lda;
        logic       ldb;
        logic       regw;
        logic       ldmdr;
        logic       irw;
        logic       dmem;
        logic [1:0] m2r;
        logic [1:0] lsp;
        logic [1:0] ssp;
    } ctl_t;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SLT = 4'd7;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t cur, nxt;
    ctl_t   ctl;
    logic   taken, br_taken;
    logic   unused_bits;

    // funct7[5] selects SUB only for register-register ops; for immediates bit 30 is immediate data
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? OP_SUB : OP_ADD;
            3'd1:    return OP_SLL;
            3'd4:    return OP_XOR;
            3'd5:    return OP_SRL;
            3'd6:    return OP_OR;
            3'd7:    return OP_AND;
            default: return OP_SLT;
        endcase
    endfunction

    function automatic state_t dispatch(input logic [6:0] op);
        case (op)
            7'b0110011: return EXEC_R;
            7'b0010011: return EXEC_I;
            7'b0000011,
            7'b0100011: return ADDR;
            7'b1100011: return BRANCH;
            7'b1101111: return JAL;
            7'b1100111: return JALR;
            7'b0110111: return LUI;
`ifdef CTRL_EXC_EN
            default:    return EXC;
`else
            default:    return FETCH;
`endif
        endcase
    endfunction

    // Splice code 0=d,1=w,2=h,3=b is the bitwise inverse of funct3[1:0]
    function automatic ctl_t decode(input state_t s, input logic [31:0] ir);
        ctl_t c;
        c = '0;
        case (s)
            FETCH2: begin c.irw = 1'b1; c.srcb = 2'd1; c.pcw = 1'b1; end
            DECODE: begin c.lda = 1'b1; c.ldb = 1'b1; c.srcb = 2'd2; c.ldaout = 1'b1; end
            EXEC_R: begin c.srca = 2'd1; c.aluop = alu_fn(ir[14:12], ir[30]); c.ldaout = 1'b1; end
            EXEC_I: begin c.srca = 2'd1; c.srcb = 2'd2; c.aluop = alu_fn(ir[14:12], 1'b0); c.ldaout = 1'b1; end
            LUI:    begin c.srca = 2'd2; c.srcb = 2'd2; c.ldaout = 1'b1; end
            WB_ALU: c.regw = 1'b1;
            ADDR:   begin c.srca = 2'd1; c.srcb = 2'd2; c.ldaout = 1'b1; end
            MEM_WR: begin c.dmem = 1'b1; c.ssp = ~ir[13:12]; end
            MEM_LD: c.ldmdr = 1'b1;
            WB_LD:  begin c.regw = 1'b1; c.m2r = 2'd1; c.lsp = ~ir[13:12]; end
            BRANCH: begin c.srca = 2'd1; c.aluop = OP_SUB; end
            BR_FIX: begin c.srcb = 2'd1; c.aluop = OP_SUB; c.pcw = 1'b1; end
            JAL:    begin c.regw = 1'b1; c.m2r = 2'd2; c.pcsrc = 2'd1; c.pcw = 1'b1; end
            JALR:   begin c.regw = 1'b1; c.m2r = 2'd2; c.srca = 2'd1; c.srcb = 2'd2; c.pcw = 1'b1; end
`ifdef CTRL_EXC_EN
            EXC:    begin c.epcw = 1'b1; c.causew = 1'b1; c.cause = ir[6:0] == OPC_SYSTEM; c.dms = 1'b1; end
            EXC_LD: begin c.dms = 1'b1; c.cause = ir[6:0] == OPC_SYSTEM; c.pcsrc = 2'd2; c.pcw = 1'b1; end
`endif
            default: ;
        endcase
        return c;
    endfunction

    // beq/bne compare equality, blt/bge compare less; funct3[0] inverts the sense
    assign taken = instruction[14] ? (alu_less ^ instruction[12]) : (alu_equal ^ instruction[12]);

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:                  nxt = FETCH2;
            FETCH2:                 nxt = DECODE;
            DECODE:                 nxt = dispatch(instruction[6:0]);
            EXEC_R, EXEC_I, LUI:    nxt = WB_ALU;
            ADDR:                   nxt = instruction[5] ? MEM_WR : MEM_RD;
            MEM_RD:                 nxt = MEM_LD;
            MEM_LD:                 nxt = WB_LD;
            BRANCH:                 nxt = taken ? BR_FIX : FETCH;
            JAL:                    nxt = BR_FIX;
`ifdef CTRL_EXC_EN
            EXC:                    nxt = EXC_LD;
`endif
            default:                nxt = FETCH;
        endcase
    end

    // Outputs are registered alongside the state so each state's strobes are glitch-free;
    // the IR is stable whenever an instruction-dependent state is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= state_t'(RESET_STATE);
            ctl <= '0;
        end else begin
            cur <= nxt;
            ctl <= decode(nxt, instruction);
        end
    end

    // The taken decision is the only flag-dependent output, so it is overlaid combinationally
    assign br_taken     = (cur == BRANCH) && taken;
    assign PCWriteState = ctl.pcw | br_taken;
    assign PCSource     = br_taken ? 2'd1 : ctl.pcsrc;
    assign DataMemSrc   = ctl.dms;
    assign IntCause     = ctl.cause;
    assign EPCWrite     = ctl.epcw;
    assign CauseWrite   = ctl.causew;
    assign ALUSrcA      = ctl.srca;
    assign ALUSrcB      = ctl.srcb;
    assign ALUOp        = ctl.aluop;
    assign LoadAOut     = ctl.ldaout;
    assign LoadRegA     = ctl.lda;
    assign LoadRegB     = ctl.ldb;
    assign RegWrite     = ctl.regw;
    assign LoadMDR      = ctl.ldmdr;
    assign IRWrite      = ctl.irw;
    assign DMemOp       = ctl.dmem;
    assign MemToReg     = ctl.m2r;
    assign LoadSplice   = ctl.lsp;
    assign StoreSplice  = ctl.ssp;
    assign state        = cur;

    assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7], alu_greater, alu_zero};
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream checked cycle by cycle against a per-instruction trace model
module tb_control_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = '0;
    logic        alu_equal = 1'b0, alu_less = 1'b0, alu_greater = 1'b0, alu_zero = 1'b0;
    logic        PCWriteState, DataMemSrc, IntCause, EPCWrite, CauseWrite;
    logic        LoadAOut, LoadRegA, LoadRegB, RegWrite, LoadMDR, IRWrite, DMemOp;
    logic [1:0]  PCSource, ALUSrcA, ALUSrcB, MemToReg, LoadSplice, StoreSplice;
    logic [3:0]  ALUOp;
    logic [4:0]  state;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .alu_equal(alu_equal), .alu_less(alu_less), .alu_greater(alu_greater), .alu_zero(alu_zero),
        .PCWriteState(PCWriteState), .PCSource(PCSource), .DataMemSrc(DataMemSrc), .IntCause(IntCause),
        .EPCWrite(EPCWrite), .CauseWrite(CauseWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .LoadAOut(LoadAOut), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .RegWrite(RegWrite),
        .LoadMDR(LoadMDR), .IRWrite(IRWrite), .DMemOp(DMemOp), .MemToReg(MemToReg),
        .LoadSplice(LoadSplice), .StoreSplice(StoreSplice), .state(state)
    );

    typedef struct packed {
        logic [4:0] st;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       dms, icause, epcw, causew;
        logic [1:0] srca, srcb;
        logic [3:0] aluop;
        logic       ldaout, lda, ldb, regw, ldmdr, irw, dmem;
        logic [1:0] m2r, lsp, ssp;
    } vec_t;

    vec_t dv;
    assign dv = {state, PCWriteState, PCSource, DataMemSrc, IntCause, EPCWrite, CauseWrite,
                 ALUSrcA, ALUSrcB, ALUOp, LoadAOut, LoadRegA, LoadRegB, RegWrite, LoadMDR,
                 IRWrite, DMemOp, MemToReg, LoadSplice, StoreSplice};

    localparam logic [4:0] S_FETCH = 0, S_FETCH2 = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4,
                           S_LUI = 5, S_WB_ALU = 6, S_ADDR = 7, S_MEM_RD = 8, S_MEM_LD = 9,
                           S_WB_LD = 10, S_MEM_WR = 11, S_BRANCH = 12, S_BR_FIX = 13, S_JAL = 14,
                           S_JALR = 15, S_EXC = 16, S_EXC_LD = 17;
    // ALUOp by funct3: add, sll, slt, sltu->slt, xor, srl, or, and
    localparam logic [3:0] ALU_TBL [8] = '{4'd0, 4'd5, 4'd7, 4'd7, 4'd4, 4'd6, 4'd3, 4'd2};

    vec_t expq[$];
    int   vectors = 0;
    int   miss = 0;

    function automatic vec_t mk(input logic [4:0] st);
        vec_t r;
        r = '0;
        r.st = st;
        return r;
    endfunction

    // Whole-instruction trace: one expected output record per cycle, FETCH first
    task automatic build(input logic [31:0] ir, input logic eq, input logic lt);
        vec_t r;
        logic [6:0] op;
        logic [2:0] f3;
        logic tk, c;
        op = ir[6:0];
        f3 = ir[14:12];
        r = mk(S_FETCH); expq.push_back(r);
        r = mk(S_FETCH2); r.irw = 1; r.srcb = 1; r.pcw = 1; expq.push_back(r);
        r = mk(S_DECODE); r.lda = 1; r.ldb = 1; r.srcb = 2; r.ldaout = 1; expq.push_back(r);
        case (op)
            7'b0110011: begin
                r = mk(S_EXEC_R); r.srca = 1; r.ldaout = 1;
                r.aluop = (f3 == 3'd0 && ir[30]) ? 4'd1 : ALU_TBL[f3];
                expq.push_back(r);
                r = mk(S_WB_ALU); r.regw = 1; expq.push_back(r);
            end
            7'b0010011: begin
                r = mk(S_EXEC_I); r.srca = 1; r.srcb = 2; r.ldaout = 1; r.aluop = ALU_TBL[f3];
                expq.push_back(r);
                r = mk(S_WB_ALU); r.regw = 1; expq.push_back(r);
            end
            7'b0110111: begin
                r = mk(S_LUI); r.srca = 2; r.srcb = 2; r.ldaout = 1; expq.push_back(r);
                r = mk(S_WB_ALU); r.regw = 1; expq.push_back(r);
            end
            7'b0000011: begin
                r = mk(S_ADDR); r.srca = 1; r.srcb = 2; r.ldaout = 1; expq.push_back(r);
                r = mk(S_MEM_RD); expq.push_back(r);
                r = mk(S_MEM_LD); r.ldmdr = 1; expq.push_back(r);
                r = mk(S_WB_LD); r.regw = 1; r.m2r = 1; r.lsp = 2'(3 - f3[1:0]); expq.push_back(r);
            end
            7'b0100011: begin
                r = mk(S_ADDR); r.srca = 1; r.srcb = 2; r.ldaout = 1; expq.push_back(r);
                r = mk(S_MEM_WR); r.dmem = 1; r.ssp = 2'(3 - f3[1:0]); expq.push_back(r);
            end
            7'b1100011: begin
                case (f3)
                    3'd0: tk = eq;
                    3'd1: tk = !eq;
                    3'd4: tk = lt;
                    default: tk = !lt;
                endcase
                r = mk(S_BRANCH); r.srca = 1; r.aluop = 1;
                if (tk) begin r.pcsrc = 1; r.pcw = 1; end
                expq.push_back(r);
                if (tk) begin
                    r = mk(S_BR_FIX); r.srcb = 1; r.aluop = 1; r.pcw = 1; expq.push_back(r);
                end
            end
            7'b1101111: begin
                r = mk(S_JAL); r.regw = 1; r.m2r = 2; r.pcsrc = 1; r.pcw = 1; expq.push_back(r);
                r = mk(S_BR_FIX); r.srcb = 1; r.aluop = 1; r.pcw = 1; expq.push_back(r);
            end
            7'b1100111: begin
                r = mk(S_JALR); r.regw = 1; r.m2r = 2; r.srca = 1; r.srcb = 2; r.pcw = 1;
                expq.push_back(r);
            end
            default: begin
                c = (op == 7'b1110011);
`ifdef CTRL_EXC_EN
                r = mk(S_EXC); r.epcw = 1; r.causew = 1; r.icause = c; r.dms = 1; expq.push_back(r);
                r = mk(S_EXC_LD); r.dms = 1; r.icause = c; r.pcsrc = 2; r.pcw = 1; expq.push_back(r);
`else
                if (c) r = mk(S_FETCH);
`endif
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (!reset && expq.size() != 0) begin
            vec_t e;
            e = expq.pop_front();
            vectors++;
            if (dv !== e) begin
                miss++;
                $display("FAIL cycle_check t=%0t state got %0d expected %0d, outputs got %h expected %h",
                         $time, dv.st, e.st, dv, e);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] ir, input logic eq, input logic lt,
                       output int cyc, output int rw, output int pcw, output int dm, output logic [1:0] ss);
        instruction = ir;
        alu_equal = eq;
        alu_less = lt;
        alu_greater = 1'($urandom);
        alu_zero = 1'($urandom);
        build(ir, eq, lt);
        cyc = 0; rw = 0; pcw = 0; dm = 0; ss = 0;
        while (expq.size() != 0 && cyc < 40) begin
            rw += int'(RegWrite);
            pcw += int'(PCWriteState);
            dm += int'(DMemOp);
            if (DMemOp) ss = StoreSplice;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 40) begin
            vectors++;
            miss++;
            $display("FAIL timeout: instruction %h still has %0d cycles pending", ir, expq.size());
            expq.delete();
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ir;
        logic [6:0]  op;
        logic [1:0]  b;
        ir = $urandom;
        case ($urandom_range(0, 9))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b1101111;
            6: op = 7'b1100111;
            7: op = 7'b0110111;
            8: op = 7'b1110011;
            default: begin
                op = 7'($urandom);
                while (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b1110011})
                    op = 7'($urandom);
            end
        endcase
        ir[6:0] = op;
        if (op == 7'b1100011) begin
            b = 2'($urandom);
            ir[14:12] = {b[1], 1'b0, b[0]};
        end
        return ir;
    endfunction

    initial begin
        int cyc, rw, pcw, dm, n;
        logic [1:0] ss;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", state, 0);
        chk("reset_outputs", dv, 0);
        reset = 1'b0;

        run(32'h002081B3, 1'b0, 1'b0, cyc, rw, pcw, dm, ss);
        chk("add_cycles", cyc, 5);
        chk("add_regwrite_pulses", rw, 1);
        chk("add_pcwrite_pulses", pcw, 1);

        run(32'h00208863, 1'b1, 1'b0, cyc, rw, pcw, dm, ss);
        chk("beq_taken_cycles", cyc, 5);
        chk("beq_taken_pcwrite_pulses", pcw, 3);

        run(32'h00208863, 1'b0, 1'b1, cyc, rw, pcw, dm, ss);
        chk("beq_not_taken_cycles", cyc, 4);
        chk("beq_not_taken_pcwrite_pulses", pcw, 1);

        run(32'h0000B183, 1'b0, 1'b0, cyc, rw, pcw, dm, ss);
        chk("ld_cycles", cyc, 7);
        chk("ld_regwrite_pulses", rw, 1);

        run(32'h00208023, 1'b0, 1'b0, cyc, rw, pcw, dm, ss);
        chk("sb_dmem_pulses", dm, 1);
        chk("sb_store_splice", ss, 3);

        run(32'h0000007F, 1'b0, 1'b0, cyc, rw, pcw, dm, ss);
        chk("illegal_regwrite_pulses", rw, 0);
`ifdef CTRL_EXC_EN
        chk("illegal_cycles", cyc, 5);
        chk("illegal_pcwrite_pulses", pcw, 2);
`else
        chk("illegal_cycles", cyc, 3);
        chk("illegal_pcwrite_pulses", pcw, 1);
`endif

        // Reset in the middle of a store must kill the write strobe without a clock edge
        instruction = 32'h00208023;
        build(instruction, 1'b0, 1'b0);
        n = 0;
        while (state != S_MEM_WR && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_mem_wr", state, S_MEM_WR);
        chk("dmem_before_reset", DMemOp, 1);
        reset = 1'b1;
        #1;
        chk("dmem_async_drop", DMemOp, 0);
        chk("state_async_reset", state, 0);
        expq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("state_after_release", state, 0);

        for (int i = 0; i < 400; i++)
            run(rand_instr(), 1'($urandom), 1'($urandom), cyc, rw, pcw, dm, ss);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
